// File: rtl/lcd_arb_pkg.sv
// Shared types and constants for the LCD message arbiter: FSM states, frame geometry
// and the character-position to bit-offset mapping of the 256-bit chars bus.
package lcd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DWELL = 2'd2
  } arb_state_t;

  localparam int LCD_CHARS_W = 256;
  localparam int LCD_NCHARS  = 32;
  localparam logic [7:0] LCD_SPACE = 8'h20;
  localparam logic [LCD_CHARS_W-1:0] LCD_BLANK = {LCD_NCHARS{LCD_SPACE}};

  // Position 0 (top-left) occupies the most significant byte of the frame.
  function automatic logic [7:0] char_lsb(input logic [4:0] pos);
    return 8'(LCD_CHARS_W - 8 - 8 * int'(pos));
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Combinational round-robin pick: the first requester strictly after ptr wins,
// wrapping around, so the previous owner is considered last.
module lcd_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_any
);

  always_comb begin : pick
    int best_d;
    int d;
    // NOTE: every output and temporary gets a default before the loop so no path
    // leaves a value unassigned, which would infer a latch.
    best_d  = NREQ;
    d       = 0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    gnt_oh  = '0;
    for (int i = 0; i < NREQ; i++) begin
      // Distance from the slot just after ptr; the owner itself ends up at NREQ-1.
      d = (i + NREQ - 1 - int'(ptr)) % NREQ;
      if (req[i] && d < best_d) begin
        best_d  = d;
        gnt_idx = IDXW'(i);
        gnt_any = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      gnt_oh[i] = gnt_any && (gnt_idx == IDXW'(i));
    end
  end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Shares the 2x16 LCD frame between NREQ requesters: round-robin burst grants,
// character assembly, and a minimum dwell per message. Optional tear-free shadow
// buffer enabled by defining LCD_SHADOW_BUFFER_EN.
module lcd_msg_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int NREQ          = 2,
  parameter int DWELL_CYCLES  = 50_000_000,
  parameter int BURST_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  output logic [NREQ-1:0]        grant,
  input  logic [NREQ-1:0]        wr_valid,
  input  logic [5*NREQ-1:0]      wr_addr,
  input  logic [8*NREQ-1:0]      wr_char,
  input  logic [NREQ-1:0]        wr_last,
  output logic [NREQ-1:0]        wr_ready,
  output logic [LCD_CHARS_W-1:0] chars,
  output logic                   frame_upd
);

  localparam int IDXW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TO_MAX    = (BURST_TIMEOUT > 1) ? BURST_TIMEOUT - 1 : 0;
  localparam int TO_W      = (TO_MAX > 0) ? $clog2(TO_MAX + 1) : 1;
  localparam int DWELL_MAX = (DWELL_CYCLES > 1) ? DWELL_CYCLES - 1 : 0;
  localparam int DW_W      = (DWELL_MAX > 0) ? $clog2(DWELL_MAX + 1) : 1;

  arb_state_t      state;
  logic [IDXW-1:0] owner;
  logic [IDXW-1:0] rr_ptr;
  logic [TO_W-1:0] idle_cnt;
  logic [DW_W-1:0] dwell_cnt;

  logic [NREQ-1:0] pick_oh;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;

  logic            sel_req;
  logic            sel_last;
  logic [4:0]      sel_addr;
  logic [7:0]      sel_char;

  logic            grant_now;
  logic            wr_accept;
  logic            burst_done;
  logic            burst_abort;

  lcd_rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // Route the current owner's write channel; other requesters are never looked at.
  always_comb begin
    sel_req  = 1'b0;
    sel_last = 1'b0;
    sel_addr = '0;
    sel_char = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDXW'(i)) begin
        sel_req  = req[i];
        sel_last = wr_last[i];
        sel_addr = wr_addr[5*i +: 5];
        sel_char = wr_char[8*i +: 8];
      end
    end
  end

  assign wr_ready    = (state == ST_BURST) ? grant : '0;
  assign wr_accept   = |(wr_valid & wr_ready);
  assign grant_now   = (state == ST_IDLE) && pick_any;
  assign burst_done  = wr_accept && sel_last;
  // A completed handshake carrying wr_last finishes the message even if req drops with it.
  assign burst_abort = (state == ST_BURST) && !burst_done &&
                       (!sel_req || (!wr_accept && idle_cnt == TO_W'(TO_MAX)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      idle_cnt  <= '0;
      dwell_cnt <= '0;
      frame_upd <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every register
      // here sees the pre-edge value of every other register.
      frame_upd <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_now) begin
            grant    <= pick_oh;
            owner    <= pick_idx;
            rr_ptr   <= pick_idx;
            idle_cnt <= '0;
            state    <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (burst_done) begin
            grant     <= '0;
            frame_upd <= 1'b1;
            dwell_cnt <= '0;
            state     <= ST_DWELL;
          end else if (burst_abort) begin
            grant <= '0;
            state <= ST_IDLE;
          end else if (wr_accept) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_DWELL: begin
          if (DWELL_CYCLES == 0 || dwell_cnt == DW_W'(DWELL_MAX)) begin
            state <= ST_IDLE;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LCD_SHADOW_BUFFER_EN
  logic [LCD_CHARS_W-1:0] shadow;
  logic [LCD_CHARS_W-1:0] shadow_wr;

  // Shadow image including this cycle's write, so the final character lands in the
  // same update that publishes the frame.
  always_comb begin
    shadow_wr = shadow;
    if (wr_accept) begin
      shadow_wr[char_lsb(sel_addr) +: 8] = sel_char;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chars  <= LCD_BLANK;
      shadow <= LCD_BLANK;
    end else begin
      if (grant_now) begin
        shadow <= chars;
      end else if (wr_accept) begin
        shadow <= shadow_wr;
      end
      if (burst_done) begin
        chars <= shadow_wr;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the frame buffer is deliberately reset; a partial message must never
      // survive reset, so this stays a register array rather than a RAM.
      chars <= LCD_BLANK;
    end else if (wr_accept) begin
      chars[char_lsb(sel_addr) +: 8] <= sel_char;
    end
  end
`endif

endmodule
